// File: rtl/jcs_io_pkg.sv
// Shared IO-port definitions for jcscpu peripherals.
// Command codes are the {io_da, io_io} pair sampled on an IO set strobe.
package jcs_io_pkg;

    localparam logic [1:0] ADDR_OUT = 2'b11;
    localparam logic [1:0] DATA_OUT = 2'b01;
    localparam logic [1:0] DATA_IN  = 2'b00;

    localparam logic [7:0] TTY_ADDR_DEF = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/jfifo_sync.sv
// Single-clock FIFO with occupancy count.
// A pop on an empty FIFO is ignored; a push when full only lands if a pop frees a slot.
module jfifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_q];

    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/jcs_tty_uart.sv
// TTY device on the jcscpu IO port: decodes select/data commands,
// queues bytes and sends them as 8N1 UART, with a readable status byte.
module jcs_tty_uart
    import jcs_io_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] TTY_ADDR     = TTY_ADDR_DEF
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] bus_in,
    input  logic       io_s,
    input  logic       io_e,
    input  logic       io_da,
    input  logic       io_io,
    output logic [7:0] bus_out,
    output logic [7:0] last_char,
    output logic       TX,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [2:0]    s_sync_q, s_sync_d;
    logic [2:0]    e_sync_q, e_sync_d;
    logic [7:0]    dev_sel_q, dev_sel_d;
    logic [7:0]    last_char_q, last_char_d;
    logic          overflow_q, overflow_d;
    logic          rd_seen_q, rd_seen_d;
    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic          set_p;
    logic          e_fall;
    logic [1:0]    cmd;
    logic          sel_hit;
    logic          wr_tty;
    logic          rd_en;
    logic          push;
    logic          pop;
    logic          drop;
    logic          busy;
    logic          baud_last;
    logic [7:0]    fifo_dout;
    logic          fifo_full_w;
    logic          fifo_empty_w;
    logic [CW-1:0] fifo_count;

    jfifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESETN),
        .push  (push),
        .pop   (pop),
        .din   (bus_in),
        .dout  (fifo_dout),
        .full  (fifo_full_w),
        .empty (fifo_empty_w),
        .count (fifo_count)
    );

    assign cmd     = {io_da, io_io};
    assign sel_hit = (dev_sel_q == TTY_ADDR);
    assign set_p   = s_sync_q[1] && !s_sync_q[2];
    assign e_fall  = e_sync_q[2] && !e_sync_q[1];
    assign wr_tty  = set_p && (cmd == DATA_OUT) && sel_hit;
    assign rd_en   = io_e && (cmd == DATA_IN) && sel_hit;
    assign busy    = (state_q != IDLE);

    assign bus_out    = rd_en ? {fifo_full_w, fifo_empty_w, overflow_q, busy, 4'b0}
                              : 8'h00;
    assign last_char  = last_char_q;
    assign TX         = tx_q;
    assign fifo_full  = fifo_full_w;
    assign fifo_empty = (fifo_count == '0);
    assign overflow   = overflow_q;

    always_comb begin
        s_sync_d    = {s_sync_q[1:0], io_s};
        e_sync_d    = {e_sync_q[1:0], io_e};
        dev_sel_d   = dev_sel_q;
        last_char_d = last_char_q;
        overflow_d  = overflow_q;
        rd_seen_d   = rd_seen_q;
        push        = wr_tty && (!fifo_full_w || pop);
        drop        = wr_tty && fifo_full_w && !pop;
        if (set_p && (cmd == ADDR_OUT)) begin
            dev_sel_d = bus_in;
        end
        if (push) begin
            last_char_d = bus_in;
        end
        if (rd_en) begin
            rd_seen_d = 1'b1;
        end else if (e_fall) begin
            rd_seen_d = 1'b0;
        end
        // A fresh drop wins over a status-read clear in the same cycle.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (e_fall && rd_seen_q) begin
            overflow_d = 1'b0;
        end
    end

    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty_w) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // TX is registered from the next state so the line is glitch-free.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            s_sync_q    <= '0;
            e_sync_q    <= '0;
            dev_sel_q   <= 8'hFF;
            last_char_q <= '0;
            overflow_q  <= 1'b0;
            rd_seen_q   <= 1'b0;
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
        end else begin
            s_sync_q    <= s_sync_d;
            e_sync_q    <= e_sync_d;
            dev_sel_q   <= dev_sel_d;
            last_char_q <= last_char_d;
            overflow_q  <= overflow_d;
            rd_seen_q   <= rd_seen_d;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
        end
    end

endmodule

// File: tb/tb_jcs_tty_uart.sv
// Directed bench for jcs_tty_uart: IO decode, UART framing,
// FIFO burst/overflow, status read and async reset abort.
module tb_jcs_tty_uart;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       io_s, io_e, io_da, io_io;
    logic [7:0] bus_out, last_char;
    logic       tx, fifo_full, fifo_empty, overflow;

    int n_cmp = 0;
    int n_err = 0;

    jcs_tty_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8),
        .TTY_ADDR     (8'h00)
    ) dut (
        .CLK        (clk),
        .RESETN     (rst_n),
        .bus_in     (bus_in),
        .io_s       (io_s),
        .io_e       (io_e),
        .io_da      (io_da),
        .io_io      (io_io),
        .bus_out    (bus_out),
        .last_char  (last_char),
        .TX         (tx),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One CPU IO set cycle: strobe high 2 clocks, low 2 clocks.
    task automatic io_cmd(input logic da, input logic io, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus_in = d;
        io_da  = da;
        io_io  = io;
        io_s   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        io_s = 1'b0;
        @(posedge clk);
    endtask

    task automatic status_read(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        io_da = 1'b0;
        io_io = 1'b0;
        io_e  = 1'b1;
        #1;
        chk(tag, bus_out, exp);
    endtask

    task automatic get_frame(output logic [9:0] f, output bit ok);
        ok = 1'b0;
        f  = '1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (tx == 1'b0) ok = 1'b1;
        end
        if (ok) begin
            repeat (2) @(negedge clk);
            f[0] = tx;
            for (int b = 1; b < 10; b++) begin
                repeat (CPB) @(negedge clk);
                f[b] = tx;
            end
        end
    endtask

    task automatic check_frame(input logic [7:0] exp);
        logic [9:0] f;
        bit         ok;
        get_frame(f, ok);
        chk($sformatf("frame_seen_%0h", exp), ok, 1);
        if (ok) begin
            chk($sformatf("start_%0h", exp), f[0], 0);
            chk($sformatf("data_%0h", exp), f[8:1], exp);
            chk($sformatf("stop_%0h", exp), f[9], 1);
        end
    endtask

    task automatic idle_watch(input string tag, input int n);
        int lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk(tag, lows, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frm;
        rst_n  = 1'b0;
        bus_in = 8'h00;
        io_s   = 1'b0;
        io_e   = 1'b0;
        io_da  = 1'b0;
        io_io  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_bus_out", bus_out, 8'h00);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_last", last_char, 8'h00);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        idle_watch("idle_after_rst", 20);

        // Data write before any select: dev_sel is 0xFF after reset.
        io_cmd(1'b0, 1'b1, 8'h41);
        idle_watch("unsel_no_frame", 60);
        chk("unsel_last", last_char, 8'h00);
        chk("unsel_empty", fifo_empty, 1);

        // Select TTY, idle status, then a single byte.
        io_cmd(1'b1, 1'b1, 8'h00);
        status_read("status_idle", 8'b0100_0000);
        io_e = 1'b0;
        fork
            io_cmd(1'b0, 1'b1, 8'h41);
            check_frame(8'h41);
        join
        chk("last_41", last_char, 8'h41);
        repeat (4) @(posedge clk);
        #1;
        chk("empty_after_41", fifo_empty, 1);

        // Burst of 10 writes while the first byte is on the wire.
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    io_cmd(1'b0, 1'b1, 8'(8'h10 + k));
                end
                status_read("status_burst", 8'b1011_0000);
                chk("burst_full", fifo_full, 1);
                chk("burst_ovf", overflow, 1);
                chk("burst_last", last_char, 8'h18);
                @(posedge clk);
                #1;
                io_e = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                chk("ovf_cleared", overflow, 0);
            end
            begin
                for (int k = 0; k < 9; k++) begin
                    check_frame(8'(8'h10 + k));
                end
            end
        join
        idle_watch("no_dropped_frame", 60);
        chk("burst_drained", fifo_empty, 1);

        // Status read while another device is selected.
        io_cmd(1'b1, 1'b1, 8'h03);
        status_read("status_other_dev", 8'h00);
        io_e = 1'b0;
        io_cmd(1'b0, 1'b1, 8'h55);
        chk("other_dev_last", last_char, 8'h18);
        idle_watch("other_dev_idle", 50);

        // Async reset in the middle of data bit 4 of 0x41.
        io_cmd(1'b1, 1'b1, 8'h00);
        io_cmd(1'b0, 1'b1, 8'h41);
        io_cmd(1'b0, 1'b1, 8'h42);
        repeat (18) @(posedge clk);
        #1;
        chk("pre_rst_bit4", tx, 0);
        chk("pre_rst_queued", fifo_empty, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_empty", fifo_empty, 1);
        chk("abort_last", last_char, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_watch("no_resume", 80);
        chk("no_resume_empty", fifo_empty, 1);

        get_frame(frm, n_cmp[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
